// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step encoding and strobe bundle.
package apu_pkg;

  localparam int unsigned FS_DIV_DEFAULT = 8192;

  typedef enum logic [2:0] {
    FS_STEP_LEN0       = 3'd0,
    FS_STEP_IDLE0      = 3'd1,
    FS_STEP_LEN_SWEEP0 = 3'd2,
    FS_STEP_IDLE1      = 3'd3,
    FS_STEP_LEN1       = 3'd4,
    FS_STEP_IDLE2      = 3'd5,
    FS_STEP_LEN_SWEEP1 = 3'd6,
    FS_STEP_ENV        = 3'd7
  } fs_step_e;

  typedef struct packed {
    logic length;
    logic sweep;
    logic env;
  } fs_strobe_t;

  function automatic fs_step_e fs_next_step(input fs_step_e s);
    return fs_step_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/apu_prescaler.sv
// Divide-by-DIV counter with synchronous clear; tc_o flags the last count.
module apu_prescaler #(
  parameter int unsigned DIV   = 8192,
  parameter int unsigned CNT_W = $clog2(DIV)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: walks the 8-step schedule and issues registered
// one-cycle strobes to the length, sweep and envelope units.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned DIV   = FS_DIV_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DIV)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       apuEnable,
  output logic       lengthClk,
  output logic       sweepClk,
  output logic       envClk,
  output logic       stepTick,
  output logic [2:0] step,
  output logic       lengthHalf
);

  logic       tc;
  fs_step_e   step_q;
  fs_strobe_t strb_q, strb_d;
  logic       tick_q;

  apu_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk_i   (clk),
    .rst_n_i (resetN),
    .clr_i   (!apuEnable),
    .tc_o    (tc)
  );

  always_comb begin
    strb_d = '0;
    unique case (step_q)
      FS_STEP_LEN0, FS_STEP_LEN1:             strb_d.length = 1'b1;
      FS_STEP_LEN_SWEEP0, FS_STEP_LEN_SWEEP1: begin
        strb_d.length = 1'b1;
        strb_d.sweep  = 1'b1;
      end
      FS_STEP_ENV:                            strb_d.env = 1'b1;
      default:                                strb_d = '0;
    endcase
  end

  // Disable takes priority over a coincident terminal count, so that step is lost.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      step_q <= FS_STEP_LEN0;
      strb_q <= '0;
      tick_q <= 1'b0;
    end else if (!apuEnable) begin
      step_q <= FS_STEP_LEN0;
      strb_q <= '0;
      tick_q <= 1'b0;
    end else if (tc) begin
      step_q <= fs_next_step(step_q);
      strb_q <= strb_d;
      tick_q <= 1'b1;
    end else begin
      strb_q <= '0;
      tick_q <= 1'b0;
    end
  end

  assign lengthClk  = strb_q.length;
  assign sweepClk   = strb_q.sweep;
  assign envClk     = strb_q.env;
  assign stepTick   = tick_q;
  assign step       = step_q;
  assign lengthHalf = step_q[0];

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with DIV=4 (one frame = 32 edges).
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       apuEnable;
  logic       lengthClk, sweepClk, envClk, stepTick, lengthHalf;
  logic [2:0] step;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Bench-side length counter: load L gives 64-L clocks before the channel stops.
  logic       len_load = 1'b0;
  logic [6:0] len_cnt  = '0;
  logic       chan_en  = 1'b0;

  always #5 clk = ~clk;

  frame_sequencer #(.DIV(4)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .apuEnable  (apuEnable),
    .lengthClk  (lengthClk),
    .sweepClk   (sweepClk),
    .envClk     (envClk),
    .stepTick   (stepTick),
    .step       (step),
    .lengthHalf (lengthHalf)
  );

  always @(posedge clk) begin
    if (len_load) begin
      len_cnt <= 7'd64 - 7'd63;
      chan_en <= 1'b1;
    end else if (lengthClk && len_cnt != 7'd0) begin
      len_cnt <= len_cnt - 7'd1;
      if (len_cnt == 7'd1) chan_en <= 1'b0;
    end
  end

  // {lengthClk, sweepClk, envClk, stepTick, step[2:0], lengthHalf}
  function automatic logic [7:0] obs();
    return {lengthClk, sweepClk, envClk, stepTick, step, lengthHalf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset a few cycles, then releases it mid-cycle; the next edge is edge 1.
  task automatic start(input logic en);
    resetN    = 1'b0;
    apuEnable = 1'b0;
    tick();
    tick();
    apuEnable = en;
    resetN    = 1'b1;
  endtask

  // Expected outputs after edge e of continuous enabled operation.
  function automatic logic [7:0] expect_after(input int e);
    logic [7:0] len_mask   = 8'b0101_0101;
    logic [7:0] sweep_mask = 8'b0100_0100;
    logic [7:0] env_mask   = 8'b1000_0000;
    logic [2:0] s          = 3'((e / 4) % 8);
    int         k;
    logic [7:0] v          = {4'b0000, s, s[0]};
    if (e % 4 == 0) begin
      k = ((e / 4) - 1) % 8;
      v[7] = len_mask[k];
      v[6] = sweep_mask[k];
      v[5] = env_mask[k];
      v[4] = 1'b1;
    end
    return v;
  endfunction

  task automatic test_reset();
    start(1'b0);
    resetN = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", obs(), 8'h00);
    end
    start(1'b1);
    for (int e = 1; e <= 4; e++) tick();
    n_cmp++;
    if (obs() !== 8'b1001_0011) begin
      n_bad++;
      $display("FAIL reset_pre_strobe: got %b want %b", obs(), 8'b1001_0011);
    end
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_async_clear: got %b want %b", obs(), 8'h00);
    end
  endtask

  task automatic test_three_frames();
    logic [7:0] exp_v;
    start(1'b1);
    for (int e = 1; e <= 96; e++) begin
      tick();
      exp_v = expect_after(e);
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("FAIL frame_edge_%0d: got %b want %b", e, obs(), exp_v);
      end
    end
  endtask

  task automatic test_disable_mid_frame();
    start(1'b1);
    for (int e = 1; e <= 10; e++) tick();
    apuEnable = 1'b0;
    for (int e = 11; e <= 20; e++) begin
      tick();
      n_cmp++;
      if (obs() !== 8'h00) begin
        n_bad++;
        $display("FAIL disabled_edge_%0d: got %b want %b", e, obs(), 8'h00);
      end
    end
    apuEnable = 1'b1;
    for (int e = 21; e <= 23; e++) begin
      tick();
      n_cmp++;
      if (obs() !== 8'h00) begin
        n_bad++;
        $display("FAIL reenable_wait_edge_%0d: got %b want %b", e, obs(), 8'h00);
      end
    end
    tick();
    n_cmp++;
    if (obs() !== 8'b1001_0011) begin
      n_bad++;
      $display("FAIL reenable_first_step: got %b want %b", obs(), 8'b1001_0011);
    end
  endtask

  task automatic test_collision();
    start(1'b1);
    for (int e = 1; e <= 11; e++) tick();
    apuEnable = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_bad++;
      $display("FAIL collision_edge: got %b want %b", obs(), 8'h00);
    end
    apuEnable = 1'b1;
    for (int e = 13; e <= 15; e++) begin
      tick();
      n_cmp++;
      if (obs() !== 8'h00) begin
        n_bad++;
        $display("FAIL collision_cnt_cleared_edge_%0d: got %b want %b", e, obs(), 8'h00);
      end
    end
    tick();
    n_cmp++;
    if (obs() !== 8'b1001_0011) begin
      n_bad++;
      $display("FAIL collision_restart_step0: got %b want %b", obs(), 8'b1001_0011);
    end
  endtask

  task automatic test_length_half();
    start(1'b0);
    resetN   = 1'b0;
    len_load = 1'b1;
    tick();
    len_load = 1'b0;
    n_cmp++;
    if ({chan_en, lengthHalf} !== 2'b10) begin
      n_bad++;
      $display("FAIL len_loaded: got %b want %b", {chan_en, lengthHalf}, 2'b10);
    end
    apuEnable = 1'b1;
    resetN    = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    n_cmp++;
    if ({chan_en, lengthHalf, lengthClk} !== 3'b111) begin
      n_bad++;
      $display("FAIL len_half_edge4: got %b want %b", {chan_en, lengthHalf, lengthClk}, 3'b111);
    end
    tick();
    n_cmp++;
    if ({chan_en, len_cnt} !== 8'h00) begin
      n_bad++;
      $display("FAIL len_expired_edge5: got %b want %b", {chan_en, len_cnt}, 8'h00);
    end
    for (int e = 6; e <= 8; e++) tick();
    n_cmp++;
    if ({lengthHalf, step} !== 4'b0010) begin
      n_bad++;
      $display("FAIL len_half_edge8: got %b want %b", {lengthHalf, step}, 4'b0010);
    end
    for (int e = 9; e <= 13; e++) tick();
    n_cmp++;
    if (chan_en !== 1'b0) begin
      n_bad++;
      $display("FAIL len_stays_off: got %b want %b", chan_en, 1'b0);
    end
  endtask

  initial begin
    resetN    = 1'b0;
    apuEnable = 1'b0;
    test_reset();
    test_three_frames();
    test_disable_mid_frame();
    test_collision();
    test_length_half();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
